// File: rtl/adc_readout_pkg.sv
// Shared types and constants for the ADC readout drain engine.
// Build option: define ADC_READOUT_CSUM_EN to append an XOR checksum byte to each frame.
package adc_readout_pkg;

    localparam int         LEN_W       = 16;
    localparam logic [7:0] HDR_DEFAULT = 8'hA5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_LEN_H,
        S_LEN_L,
        S_POP,
        S_LATCH,
        S_SEND,
        S_CSUM,
        S_DONE
    } state_t;

`ifdef ADC_READOUT_CSUM_EN
    localparam int     FRAME_OVERHEAD = 4;
    localparam state_t TAIL_STATE     = S_CSUM;
`else
    localparam int     FRAME_OVERHEAD = 3;
    localparam state_t TAIL_STATE     = S_DONE;
`endif

endpackage

// File: rtl/adc_readout.sv
// Drains FRAME_LEN samples from the ADC FIFO and emits header, length, samples (and checksum
// when ADC_READOUT_CSUM_EN is defined) over a valid/ready byte link.
module adc_readout
    import adc_readout_pkg::*;
#(
    parameter int         DATA_W    = 8,
    parameter int         FRAME_LEN = 1024,
    parameter logic [7:0] HDR_BYTE  = HDR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              fifo_rdy,
    output logic              fifo_rden,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              frame_done
);

    if (FRAME_LEN < 1 || FRAME_LEN > 65535) begin : g_bad_frame_len
        $error("adc_readout: FRAME_LEN must be in 1..65535");
    end
    if (DATA_W != 8) begin : g_bad_data_w
        $error("adc_readout: DATA_W must be 8");
    end

    localparam logic [LEN_W-1:0] FRAME_LEN_V = LEN_W'(FRAME_LEN);

    state_t             state;
    logic [LEN_W-1:0]   sample_cnt;
    logic [DATA_W-1:0]  ctl_byte;
    state_t             ctl_next;
`ifdef ADC_READOUT_CSUM_EN
    logic [DATA_W-1:0]  csum;
`endif

    // NOTE: the pop strobe is decoded from state so the FIFO data lands exactly in LATCH,
    // keeping the 3-cycle POP/LATCH/SEND sample cadence.
    assign fifo_rden = (state == S_POP) && fifo_rdy;

    // Framing bytes and their successor state; shared by every non-sample byte state.
    always_comb begin
        ctl_byte = '0;
        ctl_next = S_IDLE;
        case (state)
            S_HDR:   begin ctl_byte = HDR_BYTE;           ctl_next = S_LEN_H; end
            S_LEN_H: begin ctl_byte = FRAME_LEN_V[15:8];  ctl_next = S_LEN_L; end
            S_LEN_L: begin ctl_byte = FRAME_LEN_V[7:0];   ctl_next = S_POP;   end
`ifdef ADC_READOUT_CSUM_EN
            S_CSUM:  begin ctl_byte = csum;               ctl_next = S_DONE;  end
`endif
            default: ;
        endcase
    end

    // NOTE: all state and output registers use non-blocking assignments so every branch
    // sees the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            sample_cnt <= '0;
`ifdef ADC_READOUT_CSUM_EN
            csum       <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A start coinciding with the completion pulse belongs to the old frame.
                    if (start && !frame_done) begin
                        busy       <= 1'b1;
                        sample_cnt <= '0;
`ifdef ADC_READOUT_CSUM_EN
                        csum       <= '0;
`endif
                        state      <= S_HDR;
                    end
                end
                S_HDR, S_LEN_H, S_LEN_L, S_CSUM: begin
                    if (!tx_valid) begin
                        tx_data  <= ctl_byte;
                        tx_valid <= 1'b1;
                    end else if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= ctl_next;
                    end
                end
                S_POP: begin
                    if (fifo_rdy) state <= S_LATCH;
                end
                S_LATCH: begin
                    tx_data    <= fifo_dout;
                    tx_valid   <= 1'b1;
                    sample_cnt <= sample_cnt + 1'b1;
`ifdef ADC_READOUT_CSUM_EN
                    csum       <= csum ^ fifo_dout;
`endif
                    state      <= S_SEND;
                end
                S_SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= (sample_cnt == FRAME_LEN_V) ? TAIL_STATE : S_POP;
                    end
                end
                S_DONE: begin
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
